// File: rtl/regfile_pkg.sv
// Shared sizing defaults, read-FSM encoding and pointer helper for the
// register-file port controller.
package regfile_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_RESP  = 2'd2
  } rd_state_e;

  // Pointer width for a ring of 'depth' slots; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback buffer: ordered FIFO of {addr, data} whose slots and valid bits
// are exported so the read path can forward from in-flight writes.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = WBUF_DEPTH_DEF,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [PTR_W-1:0]              rd_ptr
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  // A full buffer refuses a push even when the head retires this cycle.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;
  assign ent_vld   = vld_q;
  assign rd_ptr    = rd_ptr_q;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = inc(rd_ptr_q);
    end
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = inc(wr_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Two-operand read front end plus buffered writeback for a 2R/1W register
// file, forwarding in-flight writes so reads see every accepted write.
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_valid,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_req,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] Read_Reg_1,
  output logic [ADDR_W-1:0] Read_Reg_2,
  output logic              Read_Reg_1_en,
  output logic              Read_Reg_2_en,
  input  logic [DATA_W-1:0] Read_Bus_1,
  input  logic [DATA_W-1:0] Read_Bus_2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Bus
);

  localparam int PTR_W = ptr_w(WBUF_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic              cmt_vld_q, cmt_vld_d;
  logic [ADDR_W-1:0] cmt_addr_q, cmt_addr_d;
  logic [DATA_W-1:0] cmt_data_q, cmt_data_d;

  logic                              fifo_full, fifo_empty;
  logic [ADDR_W-1:0]                 head_addr;
  logic [DATA_W-1:0]                 head_data;
  logic [WBUF_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [WBUF_DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [WBUF_DEPTH-1:0]             ent_vld;
  logic [PTR_W-1:0]                  fifo_rd_ptr;

  logic rd_accept, wb_accept, wb_push, commit_en, issue;
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rbus, fwd;
  logic [PTR_W-1:0]       slot;

  // Writes to r0 are acknowledged but never enter the buffer.
  assign wb_ready  = !rst && !fifo_full;
  assign wb_accept = wb_req && wb_ready;
  assign wb_push   = wb_accept && (wb_addr != '0);
  assign commit_en = !rst && !fifo_empty;

  assign RegWrite  = commit_en;
  assign Write_Reg = commit_en ? head_addr : '0;
  assign Write_Bus = commit_en ? head_data : '0;

  assign rd_ready  = !rst && ((state_q == RD_IDLE) || ((state_q == RD_RESP) && rd_ack));
  assign rd_accept = rd_req && rd_ready;
  assign issue     = !rst && (state_q == RD_ISSUE);
  assign rd_valid  = !rst && (state_q == RD_RESP);

  assign Read_Reg_1    = issue ? addr_a_q : '0;
  assign Read_Reg_2    = issue ? addr_b_q : '0;
  assign Read_Reg_1_en = issue;
  assign Read_Reg_2_en = issue;
  assign rd_data_a     = rst ? '0 : data_a_q;
  assign rd_data_b     = rst ? '0 : data_b_q;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (commit_en),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .ent_vld   (ent_vld),
    .rd_ptr    (fifo_rd_ptr)
  );

  // Later matches override earlier ones: bus, commit, buffer head->tail,
  // then the incoming write, so the youngest value wins.
  always_comb begin
    raddr[0] = addr_a_q;
    raddr[1] = addr_b_q;
    rbus[0]  = Read_Bus_1;
    rbus[1]  = Read_Bus_2;
    slot     = '0;
    fwd      = '0;
    for (int p = 0; p < 2; p++) begin
      fwd[p] = rbus[p];
      if (cmt_vld_q && (cmt_addr_q == raddr[p]))
        fwd[p] = cmt_data_q;
      for (int k = 0; k < WBUF_DEPTH; k++) begin
        slot = PTR_W'((int'(fifo_rd_ptr) + k) % WBUF_DEPTH);
        if (ent_vld[slot] && (ent_addr[slot] == raddr[p]))
          fwd[p] = ent_data[slot];
      end
      if (wb_push && (wb_addr == raddr[p]))
        fwd[p] = wb_data;
      if (raddr[p] == '0)
        fwd[p] = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    cmt_vld_d  = commit_en;
    cmt_addr_d = head_addr;
    cmt_data_d = head_data;
    case (state_q)
      RD_IDLE:  if (rd_accept) state_d = RD_ISSUE;
      RD_ISSUE: begin
        state_d  = RD_RESP;
        data_a_d = fwd[0];
        data_b_d = fwd[1];
      end
      RD_RESP:  if (rd_ack) state_d = rd_accept ? RD_ISSUE : RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
    if (rd_accept) begin
      addr_a_d = rd_addr_a;
      addr_b_d = rd_addr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      cmt_vld_q  <= 1'b0;
      cmt_addr_q <= '0;
      cmt_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      cmt_vld_q  <= cmt_vld_d;
      cmt_addr_q <= cmt_addr_d;
      cmt_data_q <= cmt_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 32x32 register file.
module tb_regfile_port_ctrl;

  logic        clk, rst;
  logic        rd_req, rd_ready, rd_valid, rd_ack;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_req, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  Read_Reg_1, Read_Reg_2, Write_Reg;
  logic        Read_Reg_1_en, Read_Reg_2_en, RegWrite;
  logic [31:0] Read_Bus_1, Read_Bus_2, Write_Bus;

  logic [31:0] rf [32];
  bit          rf_init;
  int          en1_cnt;
  logic [4:0]  wr_log_addr [$];
  logic [31:0] wr_log_data [$];

  int n_chk, n_fail;
  int e0, w0, n7;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_valid(rd_valid), .rd_ack(rd_ack), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_req(wb_req), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .Read_Reg_1(Read_Reg_1), .Read_Reg_2(Read_Reg_2),
    .Read_Reg_1_en(Read_Reg_1_en), .Read_Reg_2_en(Read_Reg_2_en),
    .Read_Bus_1(Read_Bus_1), .Read_Bus_2(Read_Bus_2),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write at posedge; r5 preloaded to 0x11.
  assign Read_Bus_1 = rf[Read_Reg_1];
  assign Read_Bus_2 = rf[Read_Reg_2];
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 5) ? 32'h11 : 32'h0;
      rf_init <= 1'b1;
    end else if (RegWrite) begin
      rf[Write_Reg] <= Write_Bus;
    end
  end

  always @(negedge clk) begin
    if (Read_Reg_1_en) en1_cnt <= en1_cnt + 1;
    if (RegWrite) begin
      wr_log_addr.push_back(Write_Reg);
      wr_log_data.push_back(Write_Bus);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_req = 0; rd_ack = 0; rd_addr_a = 0; rd_addr_b = 0;
    wb_req = 0; wb_addr = 0; wb_data = 0;
    repeat (2) tick;
    chk("rst_ctl", {rd_valid, rd_ready, wb_ready, RegWrite, Read_Reg_1_en, Read_Reg_2_en}, 0);
    chk("rst_bus", {Read_Reg_1, Read_Reg_2, Write_Reg, Write_Bus}, 0);
    chk("rst_data", {rd_data_a, rd_data_b}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {rd_ready, wb_ready, rd_valid}, 3'b110);

    // Basic read
    tick;
    e0 = en1_cnt;
    rd_req = 1; rd_addr_a = 5; rd_addr_b = 0;
    #1 chk("s1_accept", rd_ready, 1);
    tick;
    rd_req = 0;
    chk("s1_issue", {Read_Reg_1_en, Read_Reg_2_en, Read_Reg_1, rd_valid}, {2'b11, 5'd5, 1'b0});
    tick;
    chk("s1_resp", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'h11, 32'h0});
    rd_ack = 1;
    tick;
    rd_ack = 0;
    chk("s1_done", rd_valid, 0);
    chk("s1_en_cnt", en1_cnt - e0, 1);

    // Bypass from buffer: read issues while r7 sits in the buffer
    tick;
    w0 = wr_log_addr.size();
    wb_req = 1; wb_addr = 7; wb_data = 32'hAA;
    rd_req = 1; rd_addr_a = 7; rd_addr_b = 5;
    #1 chk("s2_wb_rdy", wb_ready, 1);
    tick;
    wb_req = 0; rd_req = 0;
    chk("s2_head", {RegWrite, Write_Reg, Write_Bus}, {1'b1, 5'd7, 32'hAA});
    tick;
    chk("s2_resp", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'hAA, 32'h11});
    rd_ack = 1;
    tick;
    rd_ack = 0;
    repeat (2) tick;
    n7 = 0;
    for (int i = w0; i < wr_log_addr.size(); i++) if (wr_log_addr[i] == 5'd7) n7++;
    chk("s2_wr7_once", n7, 1);
    chk("s2_rf7", rf[7], 32'hAA);

    // Youngest wins: r3=1, r3=2, r3=3 arriving in the ISSUE cycle
    wb_req = 1; wb_addr = 3; wb_data = 1;
    tick;
    wb_data = 2; rd_req = 1; rd_addr_a = 3; rd_addr_b = 0;
    tick;
    wb_data = 3; rd_req = 0;
    tick;
    wb_req = 0;
    chk("s3_resp", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'h3, 32'h0});
    rd_ack = 1;
    tick;
    rd_ack = 0;
    repeat (3) tick;
    chk("s3_rf3", rf[3], 32'h3);

    // Full buffer with retirement stalled
    force dut.commit_en = 1'b0;
    w0 = wr_log_addr.size();
    for (int i = 0; i < 4; i++) begin
      wb_req = 1; wb_addr = 5'(10 + i); wb_data = 32'hA0 + 32'(i);
      #1 chk("s4_fill_rdy", wb_ready, 1);
      tick;
    end
    wb_addr = 14; wb_data = 32'hA4;
    #1 chk("s4_full", wb_ready, 0);
    tick;
    release dut.commit_en;
    #1 chk("s4_full_pop", {wb_ready, RegWrite}, 2'b01);
    tick;
    chk("s4_after_pop", wb_ready, 1);
    tick;
    wb_req = 0;
    repeat (6) tick;
    chk("s4_nwr", wr_log_addr.size() - w0, 5);
    for (int i = 0; i < 5; i++)
      if (w0 + i < wr_log_addr.size())
        chk("s4_order", {wr_log_addr[w0+i], wr_log_data[w0+i]}, {5'(10 + i), 32'hA0 + 32'(i)});

    // Backpressure: response held, concurrent write to r3 must not disturb it
    rd_req = 1; rd_addr_a = 3; rd_addr_b = 7;
    tick;
    rd_req = 0;
    tick;
    rd_req = 1; rd_addr_a = 5; rd_addr_b = 10; rd_ack = 0;
    wb_req = 1; wb_addr = 3; wb_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s5_hold", {rd_ready, rd_valid, rd_data_a, rd_data_b}, {2'b01, 32'h3, 32'hAA});
      tick;
      wb_req = 0;
    end
    rd_ack = 1;
    #1 chk("s5_ack_rdy", rd_ready, 1);
    tick;
    rd_ack = 0; rd_req = 0;
    chk("s5_reissue", {Read_Reg_1_en, Read_Reg_1, rd_valid}, {1'b1, 5'd5, 1'b0});
    tick;
    chk("s5_resp", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'h11, 32'hA0});
    rd_ack = 1;
    tick;
    rd_ack = 0;

    // Reset mid-RESP with two pending writes
    tick;
    force dut.commit_en = 1'b0;
    wb_req = 1; wb_addr = 20; wb_data = 32'hBB;
    rd_req = 1; rd_addr_a = 20; rd_addr_b = 21;
    tick;
    wb_addr = 21; wb_data = 32'hCC; rd_req = 0;
    tick;
    wb_req = 0;
    chk("s6_resp", {rd_valid, rd_data_a, rd_data_b}, {1'b1, 32'hBB, 32'hCC});
    rst = 1;
    #1 chk("s6_in_rst", {rd_valid, rd_ready, wb_ready, RegWrite}, 0);
    w0 = wr_log_addr.size();
    tick;
    rst = 0;
    release dut.commit_en;
    #1 chk("s6_no_wr", RegWrite, 0);
    repeat (5) tick;
    chk("s6_nwr", wr_log_addr.size() - w0, 0);
    chk("s6_state", {rd_valid, rd_ready, wb_ready}, 3'b011);
    chk("s6_rf20", rf[20], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data width; ADDR_W, default 5, register address width; WBUF_DEPTH, default 4, write-buffer entries.
REQ-002 SHALL have ports:
- clk  in  1  single clock for all logic; also clocks the register file.
- rst  in  1  reset; synchronous, active-high.
- rd_req  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_req && rd_ready.
- rd_addr_a  in  5  operand A register.
- rd_addr_b  in  5  operand B register.
- rd_valid  out  1  response valid; held until rd_ack.
- rd_ack  in  1  response consumed.
- rd_data_a  out  32  operand A value.
- rd_data_b  out  32  operand B value.
- wb_req  in  1  writeback request valid.
- wb_ready  out  1  writeback accepted when wb_req && wb_ready.
- wb_addr  in  5  destination register.
- wb_data  in  32  writeback data.
- Read_Reg_1  out  5  register-file read address 1.
- Read_Reg_2  out  5  register-file read address 2.
- Read_Reg_1_en  out  1  read port 1 enable.
- Read_Reg_2_en  out  1  read port 2 enable.
- Read_Bus_1  in  32  register-file read data 1, valid at the negedge of the issue cycle.
- Read_Bus_2  in  32  register-file read data 2, valid at the negedge of the issue cycle.
- RegWrite  out  1  register-file write strobe.
- Write_Reg  out  5  register-file write address.
- Write_Bus  out  32  register-file write data.

Function
REQ-003 Read FSM SHALL have states IDLE, ISSUE and RESP.
REQ-004 Read FSM transitions:
- IDLE -> ISSUE on accept.
- ISSUE -> RESP unconditionally.
- RESP -> IDLE on rd_ack without a new accept.
- RESP -> ISSUE on rd_ack with a same-cycle accept.
REQ-005 rd_ready SHALL be 1 in IDLE, 1 in RESP only when rd_ack=1, and 0 otherwise.
REQ-006 On accept, addresses SHALL be registered; in ISSUE they SHALL drive Read_Reg_1/2 with Read_Reg_1_en = Read_Reg_2_en = 1.
REQ-007 Both read enables SHALL be 0 outside ISSUE.
REQ-008 Read_Bus_1/2 SHALL be captured at the end of ISSUE; rd_valid=1 from the next cycle, so request-to-response latency is 2 cycles.
REQ-009 rd_data_a/b SHALL remain stable while rd_valid=1 and rd_ack=0.
REQ-010 Address 0 SHALL return 0 and SHALL NOT be forwarded.
REQ-011 For a nonzero address, the response SHALL reflect every write accepted up to and including the ISSUE cycle.
REQ-012 Forwarding priority, youngest first:
- same-cycle incoming wb (wb_req && wb_ready);
- write-buffer entries, tail to head;
- commit stage;
- Read_Bus.
REQ-013 The write buffer SHALL be a FIFO of WBUF_DEPTH entries {addr, data}.
REQ-014 wb_ready SHALL equal !full; a push is refused when full, even if a pop occurs in the same cycle.
REQ-015 A write to address 0 SHALL be accepted and discarded (not enqueued).
REQ-016 When the buffer is non-empty, the head SHALL be driven on Write_Reg/Write_Bus with RegWrite=1 for one cycle, then popped; one write retires per cycle.
REQ-017 RegWrite SHALL be 0 when the buffer is empty, with Write_Reg/Write_Bus held at 0.
REQ-018 A popped entry SHALL be held in the commit stage for one further cycle for forwarding, then invalidated.
REQ-019 A simultaneous push and pop on a non-full buffer SHALL keep the occupancy unchanged and preserve order.
REQ-020 FIFO pointers SHALL wrap modulo WBUF_DEPTH; full and empty SHALL be distinguished by an occupancy count.

Reset
REQ-021 On rst=1 at a clk posedge, the block SHALL enter IDLE, empty the buffer, invalidate the commit stage and clear the captured data.
REQ-022 During reset, outputs SHALL be: rd_valid=0, rd_ready=0, wb_ready=0, RegWrite=0, both read enables 0, and all address and data outputs 0.
REQ-023 Reset during ISSUE or RESP SHALL drop the response; pending writes SHALL be discarded and not issued.

Structure
REQ-024 ADDR_W, DATA_W, WBUF_DEPTH defaults and the FSM state encodings SHALL live in shared package regfile_pkg.
REQ-025 The write buffer SHALL be sub-module wb_fifo, exposing its entries and valid bits for the forwarding compare.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Basic read: RF r5=0x11, rd_req (5,0) -> rd_valid 2 cycles later with a=0x11, b=0; Read_Reg_1_en high for exactly 1 cycle.
- Bypass from buffer: wb r7=0xAA accepted, read r7 in the next cycle -> a=0xAA; RegWrite for r7 is seen exactly once.
- Youngest wins: wb r3=1, r3=2, then r3=3 in the ISSUE cycle -> a=3; the RF ends with r3=3.
- Full buffer: 4 writes while the test forces RegWrite to stall -> wb_ready=0 on the 5th; it is accepted after the first pop, with order preserved.
- Backpressure: rd_ack held 0 for 3 cycles -> data stable and rd_ready=0; ack with a new rd_req goes straight to ISSUE.
- Reset mid-RESP with 2 pending writes -> rd_valid=0 and no RegWrite pulse follows.
